pci_bus_arbiter: RTL and testbench



---
 rtl/pci_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// Central round-robin arbiter for a shared PCI bus segment: issues at most one
// active-low grant, tracks FRAME/IRDY, and revokes grants that never start.
module pci_bus_arbiter #(
  parameter int N_MASTERS     = 4,
  parameter int START_TIMEOUT = 16,
  parameter int OWNER_W       = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] REQ,
  output logic [N_MASTERS-1:0] GNT,
  input  logic                 FRAME,
  input  logic                 IRDY,
  output logic [OWNER_W-1:0]   bus_owner,
  output logic                 bus_busy,
  output logic                 timeout_pulse
);

  localparam int CNT_W  = $clog2(START_TIMEOUT + 1);
  localparam int CAND_W = OWNER_W + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [OWNER_W-1:0]   LAST_RST = OWNER_W'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] ALL_HIGH = {N_MASTERS{1'b1}};
  localparam logic [N_MASTERS-1:0] ONE_HOT0 = N_MASTERS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2
  } state_t;

  state_t                 state_r;
  logic [OWNER_W-1:0]     last_r;
  logic [OWNER_W-1:0]     owner_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [N_MASTERS-1:0]   gnt_r;
  logic                   busy_r;
  logic                   tmo_r;

  logic                   bus_idle_s;
  logic                   pick_valid_s;
  logic [OWNER_W-1:0]     pick_idx_s;
  logic                   owner_req_low_s;
  logic                   other_req_low_s;
  logic [N_MASTERS-1:0]   owner_mask_s;

  // Returns {valid, index} of the first requester after 'last', wrapping at N_MASTERS.
  function automatic logic [OWNER_W:0] rr_pick(input logic [N_MASTERS-1:0] req_low,
                                               input logic [OWNER_W-1:0]   last);
    logic [OWNER_W:0] res;
    logic [CAND_W-1:0] cand;
    res = {(OWNER_W+1){1'b0}};
    for (int i = N_MASTERS; i >= 1; i--) begin
      cand = {1'b0, last} + CAND_W'(i);
      if (cand >= CAND_W'(N_MASTERS)) cand = cand - CAND_W'(N_MASTERS);
      if (req_low[cand[OWNER_W-1:0]]) res = {1'b1, cand[OWNER_W-1:0]};
    end
    return res;
  endfunction

  // Bus status and round-robin candidate for the next grant.
  always_comb begin
    bus_idle_s                 = FRAME & IRDY;
    {pick_valid_s, pick_idx_s} = rr_pick(~REQ, last_r);
    owner_mask_s               = ONE_HOT0 << owner_r;
    owner_req_low_s            = ~REQ[owner_r];
    other_req_low_s            = |(~REQ & ~owner_mask_s);
  end

  // Arbitration state machine with registered grant and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= ALL_HIGH;
      owner_r <= {OWNER_W{1'b0}};
      last_r  <= LAST_RST;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      tmo_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Grants only start on an idle bus, so a transaction in flight at reset is left alone.
          if (bus_idle_s && pick_valid_s) begin
            gnt_r   <= ~(ONE_HOT0 << pick_idx_s);
            owner_r <= pick_idx_s;
            last_r  <= pick_idx_s;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= GRANTED;
          end else begin
            gnt_r   <= ALL_HIGH;
          end
        end
        GRANTED: begin
          if (!FRAME) begin
            busy_r  <= 1'b1;
            state_r <= BUSY;
          end else if (!owner_req_low_s) begin
            gnt_r   <= ALL_HIGH;
            state_r <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            gnt_r   <= ALL_HIGH;
            tmo_r   <= 1'b1;
            state_r <= IDLE;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r   <= cnt_r + CNT_ONE;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        BUSY: begin
          // Dropping GNT only stops the owner from starting another cycle; it finishes the current one.
          if (bus_idle_s) begin
            gnt_r   <= ALL_HIGH;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (!owner_req_low_s || other_req_low_s) begin
            gnt_r   <= ALL_HIGH;
          end else begin
            gnt_r   <= gnt_r;
          end
        end
        default: begin
          gnt_r   <= ALL_HIGH;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign GNT           = gnt_r;
  assign bus_owner     = owner_r;
  assign bus_busy      = busy_r;
  assign timeout_pulse = tmo_r;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Scoreboard bench for pci_bus_arbiter: directed bus scenarios push expected
// grant/revoke/busy events; a monitor pops and compares them as they occur.
`timescale 1ns/1ps
module tb_pci_bus_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int OW  = $clog2(N);
  localparam logic [N-1:0] ALL = {N{1'b1}};
  localparam int EV_GRANT  = 0;
  localparam int EV_REVOKE = 1;
  localparam int EV_BUSY   = 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [N-1:0]  REQ   = 4'b1111;
  logic          FRAME = 1'b1;
  logic          IRDY  = 1'b1;
  logic [N-1:0]  GNT;
  logic [OW-1:0] bus_owner;
  logic          bus_busy;
  logic          timeout_pulse;

  always #5 clk = ~clk;

  pci_bus_arbiter #(.N_MASTERS(N), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .REQ(REQ), .GNT(GNT), .FRAME(FRAME), .IRDY(IRDY),
    .bus_owner(bus_owner), .bus_busy(bus_busy), .timeout_pulse(timeout_pulse)
  );

  typedef struct { int kind; int idx; int len; bit tmo; } ev_t;
  ev_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int k, input int i, input int l, input bit t);
    ev_t e;
    e.kind = k; e.idx = i; e.len = l; e.tmo = t;
    exp_q.push_back(e);
  endtask

  task automatic pop_expect(input int kind, output ev_t e, output bit ok);
    e = '{kind: -1, idx: -1, len: 0, tmo: 1'b0};
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got event kind %0d, expected none (t=%0t)", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  function automatic int low_idx(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (!g[i]) r = i;
    return r;
  endfunction

  logic [N-1:0] prev_gnt  = ALL;
  logic         prev_busy = 1'b0;
  int           glen      = 0;
  ev_t          cur_e;
  bit           ok_b;

  // Monitor: samples 1ns after each rising edge and checks events against the queue.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("rst_gnt", int'(GNT), int'(ALL));
      check("rst_owner", int'(bus_owner), 0);
      check("rst_busy", int'(bus_busy), 0);
      check("rst_timeout", int'(timeout_pulse), 0);
    end
    check("one_hot_gnt", ($countones(~GNT) <= 1) ? 1 : 0, 1);
    if (prev_gnt != ALL && GNT != ALL) check("handover_gap", int'(GNT), int'(prev_gnt));
    if (prev_gnt == ALL && GNT != ALL) begin
      pop_expect(EV_GRANT, cur_e, ok_b);
      if (ok_b) begin
        check("grant_idx", low_idx(GNT), cur_e.idx);
        check("grant_owner", int'(bus_owner), cur_e.idx);
      end
      glen = 1;
    end else if (prev_gnt != ALL && GNT == ALL) begin
      pop_expect(EV_REVOKE, cur_e, ok_b);
      if (ok_b) begin
        check("revoke_idx", low_idx(prev_gnt), cur_e.idx);
        check("grant_len", glen, cur_e.len);
        check("revoke_timeout", int'(timeout_pulse), int'(cur_e.tmo));
      end
      glen = 0;
    end else begin
      if (GNT != ALL) glen++;
      check("stray_timeout", int'(timeout_pulse), 0);
    end
    if (bus_busy != prev_busy) begin
      pop_expect(EV_BUSY, cur_e, ok_b);
      if (ok_b) check("busy_value", int'(bus_busy), cur_e.idx);
    end
    prev_gnt  = GNT;
    prev_busy = bus_busy;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_bus(input logic v);
    FRAME = v;
    IRDY  = v;
  endtask

  // Directed scenarios; inputs change on falling edges.
  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(20);

    // Device 0: FRAME two cycles after grant, held three cycles.
    REQ = 4'b1110;
    push(EV_GRANT, 0, 0, 1'b0); push(EV_BUSY, 1, 0, 1'b0);
    push(EV_REVOKE, 0, 5, 1'b0); push(EV_BUSY, 0, 0, 1'b0);
    cyc(2); set_bus(1'b0); cyc(3); set_bus(1'b1); REQ = 4'b1111; cyc(4);

    rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);

    // All requesting: round robin 0,1,2,3,0 with two-cycle transactions.
    REQ = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      push(EV_GRANT, k % 4, 0, 1'b0); push(EV_BUSY, 1, 0, 1'b0);
      push(EV_REVOKE, k % 4, 2, 1'b0); push(EV_BUSY, 0, 0, 1'b0);
      cyc(1); set_bus(1'b0); cyc(2); set_bus(1'b1);
      if (k == 4) REQ = 4'b1111;
      cyc(1);
    end
    cyc(3);

    // Start timeout on device 2, then device 3 wins the next search.
    REQ = 4'b1011;
    push(EV_GRANT, 2, 0, 1'b0); push(EV_REVOKE, 2, TMO, 1'b1);
    push(EV_GRANT, 3, 0, 1'b0); push(EV_BUSY, 1, 0, 1'b0);
    push(EV_REVOKE, 3, 2, 1'b0); push(EV_BUSY, 0, 0, 1'b0);
    cyc(17); REQ = 4'b0011;
    cyc(1); set_bus(1'b0); cyc(2); set_bus(1'b1); REQ = 4'b1111; cyc(3);

    // Device 1 busy, device 3 requests: early GNT release, re-grant after turnaround.
    REQ = 4'b1101;
    push(EV_GRANT, 1, 0, 1'b0); push(EV_BUSY, 1, 0, 1'b0);
    push(EV_REVOKE, 1, 3, 1'b0); push(EV_BUSY, 0, 0, 1'b0);
    push(EV_GRANT, 3, 0, 1'b0); push(EV_REVOKE, 3, 1, 1'b0);
    cyc(1); set_bus(1'b0); cyc(2); REQ = 4'b0101; cyc(2); set_bus(1'b1);
    cyc(2); REQ = 4'b1111; cyc(3);

    // Reset during device 0 transaction; no grant until bus idle, search restarts at 0.
    REQ = 4'b1110;
    push(EV_GRANT, 0, 0, 1'b0); push(EV_BUSY, 1, 0, 1'b0);
    push(EV_REVOKE, 0, 3, 1'b0); push(EV_BUSY, 0, 0, 1'b0);
    push(EV_GRANT, 0, 0, 1'b0); push(EV_REVOKE, 0, 1, 1'b0);
    cyc(1); set_bus(1'b0); cyc(2); rst = 1'b1; cyc(1); rst = 1'b0; REQ = 4'b1100;
    cyc(2); set_bus(1'b1); cyc(1); REQ = 4'b1111; cyc(4);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
